// File: rtl/net_scheduler.sv
// Inference scheduler: queues host requests, sequences one network run per tag,
// checks the run with a strobe count and a watchdog, and holds the result until consumed.
module net_scheduler #(
  parameter int CLASS_NUM = 10,
  parameter int TIMEOUT   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_tag,
  output logic       req_ready,
  output logic       conv_start,
  input  logic       fc_ready,
  input  logic       fc_complete,
  input  logic [7:0] net_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_class,
  output logic [3:0] res_tag,
  output logic       res_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never waits on ready, and a held result keeps its payload stable until taken.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [3:0]      fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q, count_d;
  logic [3:0]      act_tag_q, act_tag_d;
  logic [3:0]      strobe_q, strobe_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      res_class_q, res_class_d;
  logic [3:0]      res_tag_q, res_tag_d;
  logic            res_err_q, res_err_d;
  logic            push, pop, q_nonempty, cap_err;

  assign req_ready  = (count_q != 2'd2);
  assign q_nonempty = (count_q != 2'd0);
  assign push       = req_valid && req_ready;

  assign cap_err = (int'(strobe_q) != CLASS_NUM) || (net_out == 8'd0) ||
                   (int'(net_out) > CLASS_NUM);

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= req_tag;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    act_tag_d   = act_tag_q;
    strobe_d    = strobe_q;
    wd_d        = wd_q;
    res_class_d = res_class_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (q_nonempty) begin
          pop       = 1'b1;
          act_tag_d = fifo_q[rd_ptr_q];
          state_d   = S_START;
        end
      end
      S_START: begin
        strobe_d = '0;
        wd_d     = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (fc_ready && (strobe_q != 4'hF)) strobe_d = strobe_q + 4'd1;
        wd_d = wd_q + WD_W'(1);
        // A completion in the watchdog's last cycle still counts as a normal finish.
        if (fc_complete) begin
          state_d = S_CAPTURE;
        end else if (wd_q == WD_LAST) begin
          state_d     = S_HOLD;
          res_err_d   = 1'b1;
          res_class_d = '0;
          res_tag_d   = act_tag_q;
        end
      end
      S_CAPTURE: begin
        res_err_d   = cap_err;
        res_class_d = cap_err ? 8'd0 : net_out;
        res_tag_d   = act_tag_q;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          if (q_nonempty) begin
            pop       = 1'b1;
            act_tag_d = fifo_q[rd_ptr_q];
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      act_tag_q   <= '0;
      strobe_q    <= '0;
      wd_q        <= '0;
      res_class_q <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_tag_q   <= act_tag_d;
      strobe_q    <= strobe_d;
      wd_q        <= wd_d;
      res_class_q <= res_class_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
    end
  end

  assign conv_start = (state_q == S_START);
  assign res_valid  = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);
  assign res_class  = res_class_q;
  assign res_tag    = res_tag_q;
  assign res_err    = res_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_net_scheduler.sv
// Directed and randomized bench for net_scheduler; results are predicted from a
// tag queue plus a per-run error rule and compared with immediate assertions.
module tb_net_scheduler;

  localparam int CLASS_NUM = 10;
  localparam int TIMEOUT   = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_tag = '0;
  logic       req_ready;
  logic       conv_start;
  logic       fc_ready = 1'b0;
  logic       fc_complete = 1'b0;
  logic [7:0] net_out = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_class;
  logic [3:0] res_tag;
  logic       res_err;
  logic       busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q [$];

  net_scheduler #(.CLASS_NUM(CLASS_NUM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .conv_start(conv_start),
    .fc_ready(fc_ready), .fc_complete(fc_complete), .net_out(net_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_tag(res_tag), .res_err(res_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference rule: a run is good only with exactly CLASS_NUM strobes and a class in 1..CLASS_NUM
  function automatic logic model_err(input int n, input logic [7:0] cls);
    int cnt;
    cnt = (n > 15) ? 15 : n;
    return (cnt != CLASS_NUM) || (cls == 8'd0) || (int'(cls) > CLASS_NUM);
  endfunction

  task automatic check_reset_outputs(input string where);
    check({where, "_req_ready"}, req_ready, 1);
    check({where, "_conv_start"}, conv_start, 0);
    check({where, "_res_valid"}, res_valid, 0);
    check({where, "_res_class"}, res_class, 0);
    check({where, "_res_tag"}, res_tag, 0);
    check({where, "_res_err"}, res_err, 0);
    check({where, "_busy"}, busy, 0);
  endtask

  // driver tasks: all called at a falling edge, return at a falling edge
  task automatic submit(input logic [3:0] tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_tag   = tag;
    @(posedge clk);
    exp_q.push_back(tag);
    @(negedge clk);
    req_valid = 1'b0;
    req_tag   = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_conv();
    int n;
    n = 0;
    while (conv_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("conv_start_seen", conv_start, 1);
    check("no_start_with_result", res_valid, 0);
    @(negedge clk);
    check("conv_start_one_cycle", conv_start, 0);
  endtask

  task automatic drive_network(input int n, input logic [7:0] cls, input logic overlap);
    for (int i = 0; i < n - (overlap ? 1 : 0); i++) begin
      fc_ready = 1'b1;
      @(negedge clk);
      fc_ready = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    fc_complete = 1'b1;
    fc_ready    = overlap;
    net_out     = cls;
    @(negedge clk);
    fc_complete = 1'b0;
    fc_ready    = 1'b0;
    check("capture_not_valid", res_valid, 0);
    @(negedge clk);
    check("res_valid_latency", res_valid, 1);
    net_out = 8'($urandom_range(0, 255));
  endtask

  task automatic stray_idle();
    for (int i = 0; i < 3; i++) begin
      fc_ready    = 1'b1;
      fc_complete = 1'b1;
      net_out     = 8'($urandom_range(1, 10));
      @(negedge clk);
    end
    fc_ready    = 1'b0;
    fc_complete = 1'b0;
    check("stray_busy", busy, 0);
    check("stray_res_valid", res_valid, 0);
    check("stray_conv_start", conv_start, 0);
  endtask

  // scoreboard: oldest accepted tag must come back with the predicted class/err
  task automatic expect_result(input logic [7:0] ec, input logic ee, input int stall);
    logic [3:0] et;
    et = 4'hx;
    if (exp_q.size() > 0) et = exp_q.pop_front();
    if (stall > 0) res_ready = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      check("res_valid", res_valid, 1);
      check("res_tag", res_tag, et);
      check("res_class", res_class, ec);
      check("res_err", res_err, ee);
      check("no_start_in_hold", conv_start, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      check("b2b_conv_start", conv_start, 1);
      check("b2b_busy", busy, 1);
    end else begin
      check("idle_busy", busy, 0);
      check("idle_res_valid", res_valid, 0);
    end
  endtask

  initial begin
    logic [3:0] t;
    logic [7:0] c;
    logic       ov, e;
    int         n, st;

    // reset values, asynchronously before any clock edge
    #1;
    check_reset_outputs("reset");
    check("reset_dbg_state_known", 32'($isunknown(dbg_state)), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single request tag 3, 10 strobes, class 7, with start latency
    res_ready = 1'b0;
    req_valid = 1'b1;
    req_tag   = 4'd3;
    @(posedge clk);
    exp_q.push_back(4'd3);
    @(negedge clk);
    req_valid = 1'b0;
    check("lat_no_start_yet", conv_start, 0);
    check("lat_still_idle", busy, 0);
    @(negedge clk);
    check("lat_conv_start", conv_start, 1);
    check("lat_busy", busy, 1);
    @(negedge clk);
    check("lat_start_pulse", conv_start, 0);
    drive_network(10, 8'd7, 1'b0);
    expect_result(8'd7, 1'b0, 0);

    // wrong strobe count: 9 strobes, class 4
    submit(4'd5);
    wait_conv();
    drive_network(9, 8'd4, 1'b0);
    expect_result(8'd0, 1'b1, 2);

    // fc_complete with a strobe on the same edge still counts it; class over range
    submit(4'd6);
    wait_conv();
    drive_network(10, 8'd11, 1'b1);
    expect_result(8'd0, 1'b1, 0);
    submit(4'd8);
    wait_conv();
    drive_network(10, 8'd10, 1'b1);
    expect_result(8'd10, 1'b0, 0);

    stray_idle();

    // watchdog: network never completes
    submit(4'd2);
    wait_conv();
    repeat (TIMEOUT - 1) @(negedge clk);
    check("timeout_not_early", res_valid, 0);
    @(negedge clk);
    check("timeout_latency", res_valid, 1);
    expect_result(8'd0, 1'b1, 0);

    // three requests back to back, result side always ready
    res_ready = 1'b1;
    submit(4'd1);
    submit(4'd2);
    submit(4'd3);
    check("queue_full_ready_low", req_ready, 0);
    drive_network(10, 8'd1, 1'b0);
    expect_result(8'd1, 1'b0, 0);
    check("ready_after_pop", req_ready, 1);
    wait_conv();
    drive_network(10, 8'd2, 1'b0);
    expect_result(8'd2, 1'b0, 0);
    wait_conv();
    drive_network(10, 8'd9, 1'b0);
    expect_result(8'd9, 1'b0, 0);

    // randomized runs
    for (int k = 0; k < 10; k++) begin
      t  = 4'($urandom_range(0, 15));
      n  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(7, 16)) : CLASS_NUM;
      c  = 8'($urandom_range(0, 12));
      ov = 1'($urandom_range(0, 1));
      st = int'($urandom_range(0, 3));
      submit(t);
      wait_conv();
      drive_network(n, c, ov);
      e = model_err(n, c);
      expect_result(e ? 8'd0 : c, e, st);
      if ($urandom_range(0, 1) == 1) stray_idle();
    end

    // reset in the middle of a run discards it
    submit(4'd6);
    wait_conv();
    repeat (3) begin
      fc_ready = 1'b1;
      @(negedge clk);
    end
    fc_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("run_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("run_reset_no_restart", busy, 0);

    // stalled result consumer with a queued request, then reset in HOLD
    res_ready = 1'b0;
    submit(4'd9);
    wait_conv();
    drive_network(10, 8'd5, 1'b0);
    submit(4'd4);
    for (int i = 0; i < 20; i++) begin
      check("stall_res_valid", res_valid, 1);
      check("stall_res_class", res_class, 5);
      check("stall_res_tag", res_tag, 9);
      check("stall_res_err", res_err, 0);
      check("stall_no_start", conv_start, 0);
      fc_ready    = 1'($urandom_range(0, 1));
      fc_complete = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    fc_ready    = 1'b0;
    fc_complete = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("hold_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("discarded_no_start", conv_start, 0);
      check("discarded_no_result", res_valid, 0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/net_scheduler.md
NET_SCHEDULER -- requirements
Module: net_scheduler

Interface
REQ-001 Parameter CLASS_NUM, default 10, number of class-score strobes expected per inference.
REQ-002 Parameter TIMEOUT, default 1000000, maximum cycles from conv_start pulse to fc_complete.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  host requests one inference.
REQ-006 req_tag  input  4  host identifier carried to the result.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready on a clock edge.
REQ-008 conv_start  output  1  one-cycle start pulse to the network.
REQ-009 fc_ready  input  1  final-layer per-class score strobe.
REQ-010 fc_complete  input  1  final layer finished.
REQ-011 net_out  input  8  class result from the output stage, 1..CLASS_NUM valid, 0 = none.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  result consumed when res_valid && res_ready on a clock edge.
REQ-014 res_class  output  8  captured class, 0 on error.
REQ-015 res_tag  output  4  tag of the request that produced the result.
REQ-016 res_err  output  1  1 = timeout, wrong strobe count or out-of-range class.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 Request queue: 2-entry tag FIFO; req_ready = queue not full; push and pop in the same cycle shall both occur, with occupancy unchanged.
REQ-019 States: IDLE, START, RUN, CAPTURE, HOLD.
REQ-020 IDLE -> START when queue non-empty; tag pops into the active-tag register on this transition.
REQ-021 START: conv_start = 1 for exactly this one cycle; strobe counter and watchdog clear; -> RUN next cycle.
REQ-022 RUN: each fc_ready increments the 4-bit strobe counter, which saturates at 15; the watchdog increments every cycle.
REQ-023 RUN -> CAPTURE on fc_complete; fc_ready in the same cycle is still counted.
REQ-024 RUN -> HOLD with res_err = 1, res_class = 0 when the watchdog reaches TIMEOUT-1 without fc_complete.
REQ-025 CAPTURE: one cycle; res_class <= net_out; res_err <= (strobe count != CLASS_NUM) || net_out == 0 || net_out > CLASS_NUM; when res_err = 1, res_class shall be 0; -> HOLD.
REQ-026 HOLD: res_valid = 1; res_class, res_tag and res_err stable until handshake; on handshake -> IDLE, or -> START directly if queue non-empty (back-to-back, no IDLE cycle).
REQ-027 fc_ready and fc_complete outside RUN/CAPTURE shall be ignored.
REQ-028 conv_start shall never be asserted while res_valid = 1.
REQ-029 Latency: conv_start is asserted 2 cycles after the accepting edge when the block is idle; res_valid rises 2 cycles after fc_complete.

Reset
REQ-030 On rst = 0, immediately: state IDLE, queue empty, req_ready = 1, conv_start = 0, res_valid = 0, res_class = 0, res_tag = 0, res_err = 0, busy = 0, counters 0.
REQ-031 Reset mid-RUN or mid-HOLD shall discard the queue and the pending result; no result is produced for discarded tags.

Verification
REQ-032 Single request tag 3; 10 fc_ready pulses, then fc_complete with net_out = 7 -> one conv_start pulse, res_valid with res_class = 7, res_tag = 3, res_err = 0.
REQ-033 Three requests (tags 1, 2, 3) offered back-to-back while busy -> req_ready low after the queue fills; results return in order 1, 2, 3 with res_ready held high, and each START follows HOLD with no IDLE cycle.
REQ-034 TIMEOUT = 50, network never completes -> res_valid at cycle 51 after conv_start, res_err = 1, res_class = 0.
REQ-035 Only 9 fc_ready pulses, then fc_complete with net_out = 4 -> res_err = 1, res_class = 0.
REQ-036 res_ready held low for 20 cycles -> res_* outputs stable and no new conv_start; then rst pulsed low mid-HOLD -> all outputs return to reset values asynchronously.
